// File: rtl/hazard_pkg.sv
// Shared types and constants for the RV32I hazard controller with
// long-latency scoreboard.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register busy tracking for outstanding long-latency writes, with an
// in-flight counter and a sticky protocol-error flag.
module hazard_scoreboard #(
    parameter  int NREG     = 32,
    parameter  int MAX_PEND = 4,
    localparam int RW       = $clog2(NREG),
    localparam int CW       = $clog2(MAX_PEND + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set_i,
    input  logic [RW-1:0]   set_rd_i,
    input  logic            lwb_valid_i,
    input  logic [RW-1:0]   lwb_rd_i,
    output logic [NREG-1:0] busy_o,
    output logic [CW-1:0]   cnt_o,
    output logic            err_o
);

    localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

    logic [NREG-1:0] busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            clr_s, ovf_s;
    logic [NREG-1:0] set_mask_s, clr_mask_s;

    // Next-state: clear before set so a same-register set/clear stays busy.
    always_comb begin
        busy_d     = busy_q;
        cnt_d      = cnt_q;
        ovf_s      = 1'b0;
        clr_s      = lwb_valid_i && (lwb_rd_i != '0) && busy_q[lwb_rd_i];
        set_mask_s = set_i ? (ONE << set_rd_i) : '0;
        clr_mask_s = clr_s ? (ONE << lwb_rd_i) : '0;
        busy_d     = ((busy_q & ~clr_mask_s) | set_mask_s) & ~ONE;
        case ({set_i, clr_s})
            2'b10: begin
                if (cnt_q == CW'(MAX_PEND)) begin
                    ovf_s = 1'b1;
                    cnt_d = cnt_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            2'b01: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: cnt_d = cnt_q;
        endcase
        err_d = err_q | (lwb_valid_i & ~clr_s) | ovf_s;
    end

    // Scoreboard state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign busy_o = busy_q;
    assign cnt_o  = cnt_q;
    assign err_o  = err_q;

endmodule

// File: rtl/hazard_ctrl_sb.sv
// Hazard controller: M/W forwarding, load-use, scoreboard and capacity stalls,
// branch flush. Define HAZARD_PERF_EN to build the performance counters.
module hazard_ctrl_sb
    import hazard_pkg::*;
#(
    parameter  int NREG     = 32,
    parameter  int MAX_PEND = 4,
    localparam int RW       = $clog2(NREG),
    localparam int CW       = $clog2(MAX_PEND + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [RW-1:0]   rs1_d,
    input  logic [RW-1:0]   rs2_d,
    input  logic [RW-1:0]   rd_d,
    input  logic            uses_rs1_d,
    input  logic            uses_rs2_d,
    input  logic            regwrite_d,
    input  logic            long_d,
    input  logic [RW-1:0]   rs1_e,
    input  logic [RW-1:0]   rs2_e,
    input  logic [RW-1:0]   rd_e,
    input  logic            regwrite_e,
    input  logic [1:0]      resultsrc_e,
    input  logic            issue_long_e,
    input  logic [RW-1:0]   rd_m,
    input  logic [RW-1:0]   rd_w,
    input  logic            regwrite_m,
    input  logic            regwrite_w,
    input  logic            lwb_valid,
    input  logic [RW-1:0]   lwb_rd,
    input  logic            pcsrc_e,
    output logic [1:0]      forward_a_e,
    output logic [1:0]      forward_b_e,
    output logic            stall_f,
    output logic            stall_d,
    output logic            flush_d,
    output logic            flush_e,
    output logic [NREG-1:0] sb_busy,
    output logic [CW-1:0]   pend_cnt,
    output logic            sb_err,
    output logic [31:0]     perf_stall,
    output logic [31:0]     perf_flush,
    output logic [31:0]     perf_full
);

    localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

    logic            set_s, lu_stall_s, sb_stall_s, full_stall_s, any_stall_s;
    logic [NREG-1:0] eb_s;
    logic [CW:0]     inflight_s;
    fwd_sel_t        fwd_a_s, fwd_b_s;

    function automatic fwd_sel_t fwd_pick(input logic [RW-1:0] rs,
                                          input logic [RW-1:0] dm, input logic wm,
                                          input logic [RW-1:0] dw, input logic ww);
        fwd_sel_t sel;
        if (wm && (dm != '0) && (rs == dm)) begin
            sel = FWD_M;
        end else if (ww && (dw != '0) && (rs == dw)) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    hazard_scoreboard #(.NREG(NREG), .MAX_PEND(MAX_PEND)) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_i       (set_s),
        .set_rd_i    (rd_e),
        .lwb_valid_i (lwb_valid),
        .lwb_rd_i    (lwb_rd),
        .busy_o      (sb_busy),
        .cnt_o       (pend_cnt),
        .err_o       (sb_err)
    );

    // Stall sources; eb_s folds in an issue happening this very cycle.
    always_comb begin
        set_s        = issue_long_e & regwrite_e & (rd_e != '0);
        eb_s         = sb_busy | (set_s ? (ONE << rd_e) : '0);
        lu_stall_s   = (resultsrc_e == RESULT_LOAD) & regwrite_e & (rd_e != '0) &
                       ((uses_rs1_d & (rs1_d == rd_e)) | (uses_rs2_d & (rs2_d == rd_e)));
        sb_stall_s   = (uses_rs1_d & eb_s[rs1_d]) | (uses_rs2_d & eb_s[rs2_d]) |
                       (regwrite_d & (rd_d != '0) & eb_s[rd_d]);
        inflight_s   = {1'b0, pend_cnt} + {{CW{1'b0}}, issue_long_e};
        full_stall_s = long_d & (inflight_s >= (CW+1)'(MAX_PEND));
        any_stall_s  = lu_stall_s | sb_stall_s | full_stall_s;
        fwd_a_s      = fwd_pick(rs1_e, rd_m, regwrite_m, rd_w, regwrite_w);
        fwd_b_s      = fwd_pick(rs2_e, rd_m, regwrite_m, rd_w, regwrite_w);
    end

    assign forward_a_e = fwd_a_s;
    assign forward_b_e = fwd_b_s;
    assign stall_f     = any_stall_s & ~pcsrc_e;
    assign stall_d     = any_stall_s & ~pcsrc_e;
    assign flush_e     = any_stall_s | pcsrc_e;
    assign flush_d     = pcsrc_e;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q, perf_full_q;

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
            perf_full_q  <= 32'd0;
        end else begin
            perf_stall_q <= perf_stall_q + {31'd0, stall_d};
            perf_flush_q <= perf_flush_q + {31'd0, pcsrc_e};
            perf_full_q  <= perf_full_q + {31'd0, full_stall_s};
        end
    end

    assign perf_stall = perf_stall_q;
    assign perf_flush = perf_flush_q;
    assign perf_full  = perf_full_q;
`else
    assign perf_stall = 32'd0;
    assign perf_flush = 32'd0;
    assign perf_full  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Self-checking bench: directed table, multi-cycle corner sequences and a
// randomized run against a behavioural model of the hazard rules.
module tb_hazard_ctrl_sb;

    localparam int NREG = 32;
    localparam int MAX_PEND = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic [4:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, lwb_rd;
    logic uses_rs1_d, uses_rs2_d, regwrite_d, long_d, regwrite_e, issue_long_e;
    logic regwrite_m, regwrite_w, lwb_valid, pcsrc_e;
    logic [1:0] resultsrc_e, forward_a_e, forward_b_e;
    logic stall_f, stall_d, flush_d, flush_e, sb_err;
    logic [31:0] sb_busy, perf_stall, perf_flush, perf_full;
    logic [2:0] pend_cnt;

    hazard_ctrl_sb #(.NREG(NREG), .MAX_PEND(MAX_PEND)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .uses_rs1_d(uses_rs1_d), .uses_rs2_d(uses_rs2_d), .regwrite_d(regwrite_d), .long_d(long_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .regwrite_e(regwrite_e),
        .resultsrc_e(resultsrc_e), .issue_long_e(issue_long_e),
        .rd_m(rd_m), .rd_w(rd_w), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .lwb_valid(lwb_valid), .lwb_rd(lwb_rd), .pcsrc_e(pcsrc_e),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .sb_busy(sb_busy), .pend_cnt(pend_cnt), .sb_err(sb_err),
        .perf_stall(perf_stall), .perf_flush(perf_flush), .perf_full(perf_full)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: set of pending registers and bookkeeping.
    bit m_busy [NREG];
    int m_pend;
    bit m_err;
    int m_ps, m_pf, m_pfull;

    typedef struct {
        logic [4:0] rs1_e, rs2_e, rd_m, rd_w, rd_e, rs1_d, rs2_d;
        logic wm, ww, we, u1, u2, pc;
        logic [1:0] rsrc, fa, fb;
        logic st, fd, fe;
    } vec_t;

    vec_t tbl[11];

    function automatic vec_t mk(input int a_rs1_e, a_rs2_e, a_rd_m, a_wm, a_rd_w, a_ww,
                                input int a_rsrc, a_we, a_rd_e, a_rs1_d, a_u1, a_rs2_d, a_u2, a_pc,
                                input int a_fa, a_fb, a_st, a_fd, a_fe);
        vec_t v;
        v.rs1_e = 5'(a_rs1_e); v.rs2_e = 5'(a_rs2_e); v.rd_m = 5'(a_rd_m); v.wm = 1'(a_wm);
        v.rd_w = 5'(a_rd_w); v.ww = 1'(a_ww); v.rsrc = 2'(a_rsrc); v.we = 1'(a_we);
        v.rd_e = 5'(a_rd_e); v.rs1_d = 5'(a_rs1_d); v.u1 = 1'(a_u1); v.rs2_d = 5'(a_rs2_d);
        v.u2 = 1'(a_u2); v.pc = 1'(a_pc); v.fa = 2'(a_fa); v.fb = 2'(a_fb);
        v.st = 1'(a_st); v.fd = 1'(a_fd); v.fe = 1'(a_fe);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        rs1_d = '0; rs2_d = '0; rd_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0;
        rd_m = '0; rd_w = '0; lwb_rd = '0; uses_rs1_d = 1'b0; uses_rs2_d = 1'b0;
        regwrite_d = 1'b0; long_d = 1'b0; regwrite_e = 1'b0; issue_long_e = 1'b0;
        regwrite_m = 1'b0; regwrite_w = 1'b0; lwb_valid = 1'b0; pcsrc_e = 1'b0;
        resultsrc_e = 2'b00;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        m_pend = 0; m_err = 1'b0; m_ps = 0; m_pf = 0; m_pfull = 0;
    endtask

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (regwrite_m && rd_m != 5'd0 && rs == rd_m) return 2'b10;
        if (regwrite_w && rd_w != 5'd0 && rs == rd_w) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit pending(input logic [4:0] r);
        return m_busy[r] || (issue_long_e && regwrite_e && rd_e != 5'd0 && rd_e == r);
    endfunction

    // Compare every output against the model, then advance the model one edge.
    task automatic check_and_step();
        bit lu, sbs, full, any, st, setv, clr;
        logic [31:0] busy_vec;
        lu   = (resultsrc_e == 2'b01) && regwrite_e && rd_e != 5'd0 &&
               ((uses_rs1_d && rs1_d == rd_e) || (uses_rs2_d && rs2_d == rd_e));
        sbs  = (uses_rs1_d && pending(rs1_d)) || (uses_rs2_d && pending(rs2_d)) ||
               (regwrite_d && rd_d != 5'd0 && pending(rd_d));
        full = long_d && (m_pend + int'(issue_long_e)) >= MAX_PEND;
        any  = lu || sbs || full;
        st   = any && !pcsrc_e;
        busy_vec = '0;
        for (int i = 0; i < NREG; i++) busy_vec[i] = m_busy[i];
        chk("rnd_fwd_a", 32'(forward_a_e), 32'(exp_fwd(rs1_e)));
        chk("rnd_fwd_b", 32'(forward_b_e), 32'(exp_fwd(rs2_e)));
        chk("rnd_stall_f", 32'(stall_f), 32'(st));
        chk("rnd_stall_d", 32'(stall_d), 32'(st));
        chk("rnd_flush_d", 32'(flush_d), 32'(pcsrc_e));
        chk("rnd_flush_e", 32'(flush_e), 32'(any || pcsrc_e));
        chk("rnd_sb_busy", sb_busy, busy_vec);
        chk("rnd_pend_cnt", 32'(pend_cnt), 32'(m_pend));
        chk("rnd_sb_err", 32'(sb_err), 32'(m_err));
`ifdef HAZARD_PERF_EN
        chk("rnd_perf_stall", perf_stall, 32'(m_ps));
        chk("rnd_perf_flush", perf_flush, 32'(m_pf));
        chk("rnd_perf_full", perf_full, 32'(m_pfull));
`else
        chk("rnd_perf_stall", perf_stall, 32'd0);
        chk("rnd_perf_flush", perf_flush, 32'd0);
        chk("rnd_perf_full", perf_full, 32'd0);
`endif
        setv = issue_long_e && regwrite_e && rd_e != 5'd0;
        clr  = lwb_valid && lwb_rd != 5'd0 && m_busy[lwb_rd];
        if (lwb_valid && !clr) m_err = 1'b1;
        if (setv && !clr && m_pend == MAX_PEND) m_err = 1'b1;
        else m_pend = m_pend + int'(setv) - int'(clr);
        if (clr) m_busy[lwb_rd] = 1'b0;
        if (setv) m_busy[rd_e] = 1'b1;
        m_ps += int'(st);
        m_pf += int'(pcsrc_e);
        m_pfull += int'(full);
    endtask

    initial begin
        tbl[0]  = mk(5, 0, 5, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
        tbl[1]  = mk(5, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[2]  = mk(5, 6, 6, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        tbl[3]  = mk(5, 5, 5, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0, 7, 1, 0, 0, 0, 1, 0, 1);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0, 7, 1, 1, 0, 0, 0, 1, 1);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);

        do_reset();
        #1;
        chk("rst_sb_busy", sb_busy, 32'd0);
        chk("rst_pend_cnt", 32'(pend_cnt), 32'd0);
        chk("rst_sb_err", 32'(sb_err), 32'd0);
        chk("rst_perf_stall", perf_stall, 32'd0);

        // Directed combinational table against an empty scoreboard.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            idle();
            rs1_e = tbl[i].rs1_e; rs2_e = tbl[i].rs2_e; rd_m = tbl[i].rd_m; regwrite_m = tbl[i].wm;
            rd_w = tbl[i].rd_w; regwrite_w = tbl[i].ww; resultsrc_e = tbl[i].rsrc;
            regwrite_e = tbl[i].we; rd_e = tbl[i].rd_e; rs1_d = tbl[i].rs1_d; uses_rs1_d = tbl[i].u1;
            rs2_d = tbl[i].rs2_d; uses_rs2_d = tbl[i].u2; pcsrc_e = tbl[i].pc;
            #1;
            chk($sformatf("tbl%0d_fwd_a", i), 32'(forward_a_e), 32'(tbl[i].fa));
            chk($sformatf("tbl%0d_fwd_b", i), 32'(forward_b_e), 32'(tbl[i].fb));
            chk($sformatf("tbl%0d_stall_f", i), 32'(stall_f), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_stall_d", i), 32'(stall_d), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_flush_d", i), 32'(flush_d), 32'(tbl[i].fd));
            chk($sformatf("tbl%0d_flush_e", i), 32'(flush_e), 32'(tbl[i].fe));
        end

        // Same-cycle issue to x9 with x9 read in D; held until after completion.
        do_reset();
        @(negedge clk);
        issue_long_e = 1'b1; regwrite_e = 1'b1; rd_e = 5'd9; rs1_d = 5'd9; uses_rs1_d = 1'b1;
        #1;
        chk("iss_stall_same", 32'(stall_d), 32'd1);
        chk("iss_flush_e", 32'(flush_e), 32'd1);
        chk("iss_busy_pre", sb_busy, 32'd0);
        @(negedge clk);
        issue_long_e = 1'b0; regwrite_e = 1'b0; rd_e = 5'd0;
        #1;
        chk("iss_busy_post", sb_busy, 32'h0000_0200);
        chk("iss_pend", 32'(pend_cnt), 32'd1);
        chk("iss_stall_hold", 32'(stall_d), 32'd1);
        @(negedge clk);
        lwb_valid = 1'b1; lwb_rd = 5'd9;
        #1;
        chk("iss_stall_lwb", 32'(stall_d), 32'd1);
        @(negedge clk);
        lwb_valid = 1'b0;
        #1;
        chk("iss_stall_rel", 32'(stall_d), 32'd0);
        chk("iss_busy_clr", sb_busy, 32'd0);
        chk("iss_pend_clr", 32'(pend_cnt), 32'd0);
        chk("iss_err", 32'(sb_err), 32'd0);

        // Capacity: fill x1..x4, full stall, swap, same-reg set/clear, overflow.
        do_reset();
        for (int r = 1; r <= 4; r++) begin
            @(negedge clk);
            issue_long_e = 1'b1; regwrite_e = 1'b1; rd_e = 5'(r);
        end
        @(negedge clk);
        idle();
        #1;
        chk("cap_pend4", 32'(pend_cnt), 32'd4);
        chk("cap_busy", sb_busy, 32'h0000_001E);
        long_d = 1'b1;
        #1;
        chk("cap_full_stall", 32'(stall_d), 32'd1);
        @(negedge clk);
        idle();
        issue_long_e = 1'b1; regwrite_e = 1'b1; rd_e = 5'd5; lwb_valid = 1'b1; lwb_rd = 5'd1;
        @(negedge clk);
        idle();
        #1;
        chk("cap_swap_pend", 32'(pend_cnt), 32'd4);
        chk("cap_swap_busy", sb_busy, 32'h0000_003C);
        chk("cap_swap_err", 32'(sb_err), 32'd0);
        issue_long_e = 1'b1; regwrite_e = 1'b1; rd_e = 5'd2; lwb_valid = 1'b1; lwb_rd = 5'd2;
        @(negedge clk);
        idle();
        #1;
        chk("same_reg_busy", sb_busy, 32'h0000_003C);
        chk("same_reg_pend", 32'(pend_cnt), 32'd4);
        issue_long_e = 1'b1; regwrite_e = 1'b1; rd_e = 5'd6;
        @(negedge clk);
        idle();
        #1;
        chk("ovf_busy", sb_busy, 32'h0000_007C);
        chk("ovf_pend_sat", 32'(pend_cnt), 32'd4);
        chk("ovf_err", 32'(sb_err), 32'd1);

        // Spurious completion, sticky error, asynchronous reset mid-cycle.
        do_reset();
        @(negedge clk);
        lwb_valid = 1'b1; lwb_rd = 5'd12;
        @(negedge clk);
        idle();
        #1;
        chk("spur_err", 32'(sb_err), 32'd1);
        chk("spur_busy", sb_busy, 32'd0);
        issue_long_e = 1'b1; regwrite_e = 1'b1; rd_e = 5'd3;
        @(negedge clk);
        idle();
        @(negedge clk);
        #1;
        chk("spur_err_sticky", 32'(sb_err), 32'd1);
        chk("spur_busy3", sb_busy, 32'h0000_0008);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", sb_busy, 32'd0);
        chk("arst_pend", 32'(pend_cnt), 32'd0);
        chk("arst_err", 32'(sb_err), 32'd0);
        do_reset();
        @(negedge clk);
        lwb_valid = 1'b1; lwb_rd = 5'd0;
        @(negedge clk);
        idle();
        #1;
        chk("x0_lwb_err", 32'(sb_err), 32'd1);

        // Performance counters: 3 stall cycles, 2 redirects.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            idle();
            if (c < 3) begin
                resultsrc_e = 2'b01; regwrite_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7; uses_rs2_d = 1'b1;
            end else begin
                pcsrc_e = 1'b1;
            end
        end
        @(negedge clk);
        idle();
        #1;
`ifdef HAZARD_PERF_EN
        chk("perf_stall", perf_stall, 32'd3);
        chk("perf_flush", perf_flush, 32'd2);
        chk("perf_full", perf_full, 32'd0);
`else
        chk("perf_stall_off", perf_stall, 32'd0);
        chk("perf_flush_off", perf_flush, 32'd0);
        chk("perf_full_off", perf_full, 32'd0);
`endif

        // Randomized run against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rs1_d = 5'($urandom_range(0, 7)); rs2_d = 5'($urandom_range(0, 7));
            rd_d = 5'($urandom_range(0, 7)); rs1_e = 5'($urandom_range(0, 7));
            rs2_e = 5'($urandom_range(0, 7)); rd_e = 5'($urandom_range(0, 7));
            rd_m = 5'($urandom_range(0, 7)); rd_w = 5'($urandom_range(0, 7));
            uses_rs1_d = 1'($urandom_range(0, 1)); uses_rs2_d = 1'($urandom_range(0, 1));
            regwrite_d = 1'($urandom_range(0, 1)); long_d = 1'($urandom_range(0, 1));
            regwrite_e = 1'($urandom_range(0, 1)); regwrite_m = 1'($urandom_range(0, 1));
            regwrite_w = 1'($urandom_range(0, 1)); resultsrc_e = 2'($urandom_range(0, 3));
            pcsrc_e = ($urandom_range(0, 4) == 0);
            issue_long_e = ($urandom_range(0, 2) == 0) && (m_pend < MAX_PEND);
            lwb_valid = ($urandom_range(0, 2) == 0);
            lwb_rd = 5'($urandom_range(0, 7));
            if (lwb_valid && !m_busy[lwb_rd] && ($urandom_range(0, 24) != 0)) lwb_valid = 1'b0;
            #1;
            check_and_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
